fwrisc_mds_issue: RTL and testbench

- Issue/writeback controller directly upstream of the multi-cycle multiply/divide/shift unit in the fwrisc execute stage.
- Accepts one decoded RV32I-shift/RV32M request from execute, maps it to the unit's 4-bit op code, launches the unit with a single-cycle valid pulse and stalls execute while the unit works.
- Captures the unit's result pulse and presents a one-cycle register-file writeback.
- Handles flush (drain and discard) and a watchdog timeout.

---
 rtl/fwrisc_mds_pkg.sv | 55 +++++
 rtl/fwrisc_mds_issue_if.sv | 44 ++++
 rtl/fwrisc_mds_issue.sv | 120 ++++++++++++
 tb/tb_fwrisc_mds_issue.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_mds_pkg.sv
// rtl/fwrisc_mds_pkg.sv - shared op/state types and op decode for the mds issue controller
package fwrisc_mds_pkg;

  localparam int MDS_OP_W = 4;

  // funct3 encodings used by the RV32I shift decode
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [MDS_OP_W-1:0] {
    MDS_SLL    = 4'd0,
    MDS_SRL    = 4'd1,
    MDS_SRA    = 4'd2,
    MDS_MUL    = 4'd3,
    MDS_MULH   = 4'd4,
    MDS_MULHSU = 4'd5,
    MDS_MULHU  = 4'd6,
    MDS_DIV    = 4'd7,
    MDS_DIVU   = 4'd8,
    MDS_REM    = 4'd9,
    MDS_REMU   = 4'd10
  } mds_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WB    = 3'd3,
    ST_DRAIN = 3'd4
  } mds_state_e;

  typedef struct packed {
    mds_op_e op;
    logic    legal;
  } mds_dec_t;

  // RV32M funct3 maps linearly onto MUL..REMU; only SLL/SRL/SRA are legal otherwise
  function automatic mds_dec_t decode_mds_op(input logic is_m, input logic [2:0] funct3,
                                             input logic f7_5);
    mds_dec_t d;
    d.op    = MDS_SLL;
    d.legal = 1'b1;
    if (is_m) begin
      d.op = mds_op_e'(4'(funct3) + 4'd3);
    end else begin
      case (funct3)
        F3_SLL:  d.op = MDS_SLL;
        F3_SRX:  d.op = f7_5 ? MDS_SRA : MDS_SRL;
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/fwrisc_mds_issue_if.sv
// rtl/fwrisc_mds_issue_if.sv - execute/unit/writeback bundle for the mds issue controller
interface fwrisc_mds_issue_if
  import fwrisc_mds_pkg::*;
#(
  parameter int RD_W = 6
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic            req_funct7_5;
  logic            req_is_m;
  logic [31:0]     req_rs1;
  logic [31:0]     req_rs2;
  logic [RD_W-1:0] req_rd;
  logic            flush;
  logic            busy;
  logic [31:0]     mds_in_a;
  logic [31:0]     mds_in_b;
  mds_op_e         mds_op;
  logic            mds_in_valid;
  logic [31:0]     mds_out;
  logic            mds_out_valid;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            err;

  // controller side
  modport slave (
    input  req_valid, req_funct3, req_funct7_5, req_is_m, req_rs1, req_rs2, req_rd,
    input  flush, mds_out, mds_out_valid,
    output req_ready, busy, mds_in_a, mds_in_b, mds_op, mds_in_valid,
    output wb_valid, wb_rd, wb_data, err
  );

  // execute / unit / regfile side
  modport master (
    output req_valid, req_funct3, req_funct7_5, req_is_m, req_rs1, req_rs2, req_rd,
    output flush, mds_out, mds_out_valid,
    input  req_ready, busy, mds_in_a, mds_in_b, mds_op, mds_in_valid,
    input  wb_valid, wb_rd, wb_data, err
  );

endinterface

// File: rtl/fwrisc_mds_issue.sv
// rtl/fwrisc_mds_issue.sv - mds issue/writeback controller; optional FWRISC_MDS_SHIFT_ZERO_BYPASS_EN
module fwrisc_mds_issue
  import fwrisc_mds_pkg::*;
#(
  parameter int RD_W           = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clock,
  input logic               reset,
  fwrisc_mds_issue_if.slave bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mds_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  mds_op_e         op_q;
  logic [RD_W-1:0] rd_q;
  logic [31:0]     wb_data_q;
  logic            in_valid_q;
  logic            err_q;

  mds_dec_t        dec;
  logic            bypass;
  logic            timeout_hit;

  // decode the presented request and spot the zero-amount shift shortcut
  always_comb begin
    dec = decode_mds_op(bus.req_is_m, bus.req_funct3, bus.req_funct7_5);
`ifdef FWRISC_MDS_SHIFT_ZERO_BYPASS_EN
    bypass = dec.legal && (dec.op <= MDS_SRA) && (bus.req_rs2[4:0] == 5'd0);
`else
    bypass = 1'b0;
`endif
    // the watchdog fires in the last WAIT cycle so err lands TIMEOUT_CYCLES after ISSUE
    timeout_hit = (state == ST_WAIT) && !bus.flush && !bus.mds_out_valid && (cnt == CNT_LAST);
  end

  assign bus.req_ready    = (state == ST_IDLE);
  assign bus.busy         = (state != ST_IDLE) || (bus.req_valid && dec.legal);
  assign bus.mds_in_a     = a_q;
  assign bus.mds_in_b     = b_q;
  assign bus.mds_op       = op_q;
  assign bus.mds_in_valid = in_valid_q;
  assign bus.wb_valid     = (state == ST_WB) && !bus.flush;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.err          = err_q | timeout_hit;

  // issue/wait/writeback sequencing with flush and watchdog handling
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= MDS_SLL;
      rd_q       <= '0;
      wb_data_q  <= '0;
      in_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      in_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            a_q  <= bus.req_rs1;
            b_q  <= bus.req_rs2;
            op_q <= dec.op;
            rd_q <= bus.req_rd;
            if (!dec.legal) begin
              err_q <= 1'b1;
            end else if (bypass) begin
              wb_data_q <= bus.req_rs1;
              state     <= ST_WB;
            end else begin
              in_valid_q <= 1'b1;
              state      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= bus.flush ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.flush) begin
            cnt   <= '0;
            state <= bus.mds_out_valid ? ST_IDLE : ST_DRAIN;
          end else if (bus.mds_out_valid) begin
            wb_data_q <= bus.mds_out;
            state     <= ST_WB;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        ST_DRAIN: begin
          // a unit that never answers must not wedge the pipeline
          if (bus.mds_out_valid || (cnt == CNT_LAST)) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_mds_issue.sv
// tb/tb_fwrisc_mds_issue.sv - self-checking bench for fwrisc_mds_issue
module tb_fwrisc_mds_issue;
  import fwrisc_mds_pkg::*;

  localparam int RD_W = 6;
  localparam int T    = 64;

  typedef struct {
    logic            is_m;
    logic [2:0]      f3;
    logic            f7;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [RD_W-1:0] rd;
    logic            legal;
    mds_op_e         op;
    logic [31:0]     data;
    int              lat;
  } vec_t;

  typedef struct {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    int              cyc;
  } wb_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fwrisc_mds_issue_if #(.RD_W(RD_W)) bus ();

  fwrisc_mds_issue #(.RD_W(RD_W), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // unit model controls
  logic        mdl_en = 1'b0;
  int          mdl_lat = 3;
  int          inject_cyc = -1;
  logic [31:0] inject_data = '0;

  // monitor state
  wb_t obs_q[$];
  int  n_issue = 0;
  int  n_err = 0;
  int  issue_cyc = 0;
  int  err_cyc = 0;

  // scoreboard state
  wb_t exp_q[$];
  int  rd_idx = 0;
  int  last_wb_cyc = 0;

  vec_t vecs[17];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] unit_calc(input mds_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = '0;
    r = '0;
    case (op)
      MDS_SLL:    r = a << b[4:0];
      MDS_SRL:    r = a >> b[4:0];
      MDS_SRA:    r = 32'($signed(a) >>> b[4:0]);
      MDS_MUL:    r = a * b;
      MDS_MULH:   begin p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})); r = p[63:32]; end
      MDS_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
      MDS_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      MDS_DIV:    r = (b == 0) ? '1 : 32'($signed(a) / $signed(b));
      MDS_DIVU:   r = (b == 0) ? '1 : a / b;
      MDS_REM:    r = (b == 0) ? a : 32'($signed(a) % $signed(b));
      MDS_REMU:   r = (b == 0) ? a : a % b;
      default:    r = '0;
    endcase
    return r;
  endfunction

  // behavioural mds unit: answers mdl_lat cycles after the in_valid cycle
  always @(posedge clock) begin
    static logic        pend = 1'b0;
    static int          rem = 0;
    static logic [31:0] res = '0;
    #2;
    bus.mds_out_valid = 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (cyc == inject_cyc) begin
        bus.mds_out_valid = 1'b1;
        bus.mds_out       = inject_data;
      end else if (pend) begin
        if (rem <= 1) begin
          bus.mds_out_valid = 1'b1;
          bus.mds_out       = res;
          pend              = 1'b0;
        end else begin
          rem = rem - 1;
        end
      end
      if (bus.mds_in_valid && mdl_en) begin
        pend = 1'b1;
        rem  = mdl_lat;
        res  = unit_calc(bus.mds_op, bus.mds_in_a, bus.mds_in_b);
      end
    end
  end

  // observe writebacks, launches and error pulses mid-cycle
  always @(negedge clock) begin
    if (bus.wb_valid) obs_q.push_back('{rd: bus.wb_rd, data: bus.wb_data, cyc: cyc});
    if (bus.mds_in_valid) begin n_issue = n_issue + 1; issue_cyc = cyc; end
    if (bus.err) begin n_err = n_err + 1; err_cyc = cyc; end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 300) begin tick(); n++; end
    if (!bus.req_ready) check("wait_ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic sb_compare();
    wb_t e, o;
    check("wb_count", 32'(obs_q.size() - rd_idx), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rd_idx < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[rd_idx];
      rd_idx++;
      check("wb_rd", 32'(o.rd), 32'(e.rd));
      check("wb_data", o.data, e.data);
      last_wb_cyc = o.cyc;
    end
    exp_q.delete();
    rd_idx = obs_q.size();
  endtask

  task automatic send(input logic is_m, input logic [2:0] f3, input logic f7, input logic [31:0] a,
                      input logic [31:0] b, input logic [RD_W-1:0] rd, output int c0);
    wait_ready();
    c0               = cyc;
    bus.req_is_m     = is_m;
    bus.req_funct3   = f3;
    bus.req_funct7_5 = f7;
    bus.req_rs1      = a;
    bus.req_rs2      = b;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int i0, e0;
    wait_ready();
    i0 = n_issue;
    e0 = n_err;
    mdl_en           = 1'b1;
    mdl_lat          = v.lat;
    bus.req_is_m     = v.is_m;
    bus.req_funct3   = v.f3;
    bus.req_funct7_5 = v.f7;
    bus.req_rs1      = v.a;
    bus.req_rs2      = v.b;
    bus.req_rd       = v.rd;
    bus.req_valid    = 1'b1;
    if (v.legal) exp_q.push_back('{rd: v.rd, data: v.data, cyc: 0});
    @(negedge clock);
    check("busy_accept", 32'(bus.busy), 32'(v.legal));
    tick();
    bus.req_valid = 1'b0;
    @(negedge clock);
    check("issue_valid", 32'(bus.mds_in_valid), 32'(v.legal));
    if (v.legal) begin
      check("issue_op", 32'(bus.mds_op), 32'(v.op));
      check("issue_b", bus.mds_in_b, v.b);
      check("ready_low", 32'(bus.req_ready), 32'd0);
    end else begin
      check("illegal_err", 32'(bus.err), 32'd1);
      check("illegal_ready", 32'(bus.req_ready), 32'd1);
    end
    tick();
    wait_ready();
    sb_compare();
    check("issue_count", 32'(n_issue - i0), 32'(v.legal));
    check("err_count", 32'(n_err - e0), 32'(!v.legal));
    if (v.legal) check("wb_latency", 32'(last_wb_cyc - issue_cyc), 32'(v.lat + 1));
  endtask

  initial begin
    int c0, e0, i0, w, s0;

    vecs[0]  = '{1'b1, 3'd0, 1'b0, 32'd7,         32'd6,         6'd5,  1'b1, MDS_MUL,    32'd42,        3};
    vecs[1]  = '{1'b0, 3'd5, 1'b1, 32'h8000_0000, 32'd4,         6'd9,  1'b1, MDS_SRA,    32'hF800_0000, 5};
    vecs[2]  = '{1'b0, 3'd1, 1'b0, 32'h0000_00F1, 32'd8,         6'd0,  1'b1, MDS_SLL,    32'h0000_F100, 5};
    vecs[3]  = '{1'b0, 3'd5, 1'b0, 32'h8000_0000, 32'd4,         6'd31, 1'b1, MDS_SRL,    32'h0800_0000, 5};
    vecs[4]  = '{1'b1, 3'd1, 1'b0, 32'h8000_0000, 32'd2,         6'd12, 1'b1, MDS_MULH,   32'hFFFF_FFFF, 3};
    vecs[5]  = '{1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd13, 1'b1, MDS_MULHSU, 32'hFFFF_FFFF, 3};
    vecs[6]  = '{1'b1, 3'd3, 1'b0, 32'h8000_0000, 32'd2,         6'd14, 1'b1, MDS_MULHU,  32'd1,         3};
    vecs[7]  = '{1'b1, 3'd4, 1'b0, 32'hFFFF_FFEC, 32'd3,         6'd15, 1'b1, MDS_DIV,    32'hFFFF_FFFA, 3};
    vecs[8]  = '{1'b1, 3'd5, 1'b1, 32'd100,       32'd7,         6'd16, 1'b1, MDS_DIVU,   32'd14,        3};
    vecs[9]  = '{1'b1, 3'd6, 1'b0, 32'hFFFF_FFEC, 32'd3,         6'd17, 1'b1, MDS_REM,    32'hFFFF_FFFE, 3};
    vecs[10] = '{1'b1, 3'd7, 1'b0, 32'd100,       32'd7,         6'd63, 1'b1, MDS_REMU,   32'd2,         3};
    vecs[11] = '{1'b0, 3'd0, 1'b0, 32'd1,         32'd1,         6'd1,  1'b0, MDS_SLL,    32'd0,         3};
    vecs[12] = '{1'b0, 3'd2, 1'b0, 32'd1,         32'd1,         6'd1,  1'b0, MDS_SLL,    32'd0,         3};
    vecs[13] = '{1'b0, 3'd3, 1'b0, 32'd1,         32'd1,         6'd1,  1'b0, MDS_SLL,    32'd0,         3};
    vecs[14] = '{1'b0, 3'd4, 1'b1, 32'd1,         32'd1,         6'd1,  1'b0, MDS_SLL,    32'd0,         3};
    vecs[15] = '{1'b0, 3'd6, 1'b0, 32'd1,         32'd1,         6'd1,  1'b0, MDS_SLL,    32'd0,         3};
    vecs[16] = '{1'b0, 3'd7, 1'b0, 32'd1,         32'd1,         6'd1,  1'b0, MDS_SLL,    32'd0,         3};

    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_is_m     = 1'b0;
    bus.req_funct3   = '0;
    bus.req_funct7_5 = 1'b0;
    bus.req_rs1      = '0;
    bus.req_rs2      = '0;
    bus.req_rd       = '0;
    bus.flush        = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_valid", 32'(bus.mds_in_valid), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // zero-amount shift
    mdl_en  = 1'b1;
    mdl_lat = 3;
    i0      = n_issue;
    exp_q.push_back('{rd: 6'd7, data: 32'hDEAD_BEEF, cyc: 0});
    send(1'b0, 3'd1, 1'b0, 32'hDEAD_BEEF, 32'h20, 6'd7, c0);
    wait_ready();
    sb_compare();
`ifdef FWRISC_MDS_SHIFT_ZERO_BYPASS_EN
    check("bypass_no_issue", 32'(n_issue - i0), 32'd0);
    check("bypass_wb_cycle", 32'(last_wb_cyc - c0), 32'd1);
`else
    check("zero_shift_issue", 32'(n_issue - i0), 32'd1);
    check("zero_shift_wb_cycle", 32'(last_wb_cyc - c0), 32'd5);
`endif

    // flush in WAIT, late result dropped, next request normal
    mdl_lat = 6;
    send(1'b1, 3'd0, 1'b0, 32'h1234, 32'd1, 6'd3, c0);
    goto(c0 + 3);
    bus.flush = 1'b1;
    @(negedge clock);
    check("flush_wait_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.flush = 1'b0;
    wait_ready();
    check("flush_wait_release", 32'(cyc - c0), 32'd8);
    sb_compare();
    run_vec(vecs[0]);

    // flush in ISSUE still launches the unit
    mdl_lat = 3;
    send(1'b1, 3'd0, 1'b0, 32'd9, 32'd9, 6'd4, c0);
    bus.flush = 1'b1;
    @(negedge clock);
    check("flush_issue_in_valid", 32'(bus.mds_in_valid), 32'd1);
    tick();
    bus.flush = 1'b0;
    wait_ready();
    check("flush_issue_release", 32'(cyc - c0), 32'd5);
    sb_compare();

    // flush coinciding with the result in WAIT
    send(1'b1, 3'd0, 1'b0, 32'd2, 32'd2, 6'd4, c0);
    goto(c0 + 4);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_collide_idle", 32'(bus.req_ready), 32'd1);
    sb_compare();

    // flush in WB suppresses the strobe
    send(1'b1, 3'd0, 1'b0, 32'd3, 32'd3, 6'd4, c0);
    goto(c0 + 5);
    bus.flush = 1'b1;
    @(negedge clock);
    check("flush_wb_suppress", 32'(bus.wb_valid), 32'd0);
    tick();
    bus.flush = 1'b0;
    check("flush_wb_idle", 32'(bus.req_ready), 32'd1);
    sb_compare();

    // flush in IDLE blocks acceptance
    wait_ready();
    i0             = n_issue;
    bus.req_is_m   = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_valid  = 1'b1;
    bus.flush      = 1'b1;
    tick();
    bus.req_valid  = 1'b0;
    bus.flush      = 1'b0;
    @(negedge clock);
    check("flush_idle_block", 32'(bus.mds_in_valid), 32'd0);
    check("flush_idle_ready", 32'(bus.req_ready), 32'd1);
    tick();
    check("flush_idle_count", 32'(n_issue - i0), 32'd0);

    // watchdog, then late response discarded in DRAIN
    mdl_en = 1'b0;
    e0 = n_err;
    send(1'b1, 3'd0, 1'b0, 32'd3, 32'd4, 6'd1, c0);
    w = 0;
    while (n_err == e0 && w < T + 20) begin tick(); w++; end
    check("timeout_err_seen", 32'(n_err - e0), 32'd1);
    check("timeout_err_latency", 32'(err_cyc - issue_cyc), 32'(T));
    check("drain_busy", 32'(bus.busy), 32'd1);
    s0          = obs_q.size();
    inject_data = 32'h0000_0BAD;
    inject_cyc  = cyc + 10;
    goto(inject_cyc);
    @(negedge clock);
    check("drain_hold", 32'(bus.req_ready), 32'd0);
    tick();
    check("drain_release", 32'(bus.req_ready), 32'd1);
    check("drain_no_wb", 32'(obs_q.size() - s0), 32'd0);
    sb_compare();

    // watchdog with no response at all: DRAIN gives up too
    e0 = n_err;
    send(1'b1, 3'd0, 1'b0, 32'd3, 32'd4, 6'd1, c0);
    w = 0;
    while (n_err == e0 && w < T + 20) begin tick(); w++; end
    check("timeout2_err_seen", 32'(n_err - e0), 32'd1);
    w = 0;
    while (!bus.req_ready && w < 3 * T) begin tick(); w++; end
    check("drain_timeout_len", 32'(cyc - err_cyc), 32'(T + 1));
    sb_compare();

    // reset while waiting on the unit
    send(1'b1, 3'd0, 1'b0, 32'd5, 32'd5, 6'd2, c0);
    goto(c0 + 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_in_a", bus.mds_in_a, 32'd0);
    check("midrst_in_b", bus.mds_in_b, 32'd0);
    check("midrst_op", 32'(bus.mds_op), 32'd0);
    check("midrst_in_valid", 32'(bus.mds_in_valid), 32'd0);
    check("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("midrst_wb_data", bus.wb_data, 32'd0);
    check("midrst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    tick();
    sb_compare();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
